instr_fetch_unit: RTL

Instruction fetch stage of the multicycle MIPS datapath. It owns the PC register and the instruction register (IR), sequences a read handshake to instruction memory, and splits the latched instruction into fields. The field outputs (`RS`, `RT`, `IMMEDIATE`) and `PC_out` directly feed the jump-target concatenation stage. `PC_out` is the post-increment PC (PC+4), which supplies bits [31:28] of the jump target. The selected jump or branch target returns through the `pc_src` redirect inputs.

---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle MIPS fetch stage owning PC/IR with a timed memory read handshake
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        ir_ack,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC_out,
  output logic [5:0]  opcode,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  RD,
  output logic [5:0]  funct,
  output logic [15:0] IMMEDIATE,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_fault
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_FAULT} state_t;
  state_t state, state_n;
  logic [31:0] pc, ir, pend_tgt, tgt, redir_tgt;
  logic [3:0] cnt;
  logic pend_v, redir, redir_now;
  assign tgt = pc_src == 2'd1 ? {branch_target[31:2], 2'b00} :
               pc_src == 2'd2 ? {jump_target[31:2], 2'b00} : pc;
  assign redir = pc_src == 2'd1 || pc_src == 2'd2;
  assign redir_now = pc_write ? redir : pend_v;
  assign redir_tgt = pc_write ? tgt : pend_tgt;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  state_n = fetch_req ? S_WAIT : S_IDLE;
      S_WAIT:  state_n = mem_ready ? S_HOLD : cnt == 4'(TIMEOUT - 1) ? S_FAULT : S_WAIT;
      S_HOLD:  state_n = ir_ack ? (fetch_req ? S_WAIT : S_IDLE) : S_HOLD;
      default: state_n = S_FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      cnt      <= '0;
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state <= state_n;
      if ((state == S_IDLE || state == S_HOLD) && pc_write) pc <= tgt;
      if (state != S_WAIT && state_n == S_WAIT) cnt <= '0;
      else if (state == S_WAIT && !mem_ready) cnt <= cnt + 4'd1;
      if (state == S_WAIT && mem_ready) begin
        ir     <= mem_rdata;
        pc     <= redir_now ? redir_tgt : pc + 32'd4;
        pend_v <= 1'b0;
      end else if (state == S_WAIT && pc_write) begin
        pend_v   <= redir;
        pend_tgt <= tgt;
      end
    end
  end
  assign mem_rd      = state == S_WAIT;
  assign mem_addr    = pc;
  assign PC_out      = pc;
  assign opcode      = ir[31:26];
  assign RS          = ir[25:21];
  assign RT          = ir[20:16];
  assign RD          = ir[15:11];
  assign funct       = ir[5:0];
  assign IMMEDIATE   = ir[15:0];
  assign ir_valid    = state == S_HOLD;
  assign busy        = state != S_IDLE;
  assign fetch_fault = state == S_FAULT;
endmodule
